byte_xor_sequencer: RTL and testbench

Sequences a stored message through the 28-byte selection mux one byte at a time. It drives the mux index 0..len-1 and takes back the selected byte on the same cycle. Each byte is XORed with one A5/1 keystream byte under a valid/ready handshake, and the encrypted or decrypted bytes are assembled into a 224-bit result register. It sits directly upstream of the byte mux's index input and directly downstream of its data output.

---
 rtl/byte_xor_sequencer.sv | 97 +++++++++
 tb/tb_byte_xor_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/byte_xor_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : byte_xor_sequencer
// Brief    : Walks a byte mux over a message and XORs each byte with A5/1 keystream.
// Revision : 1.0
// ============================================================================
module byte_xor_sequencer #(
    parameter int NUM_BYTES   = 28,
    parameter int INDEX_WIDTH = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [INDEX_WIDTH-1:0]   msg_len,
    output logic [INDEX_WIDTH-1:0]   mux_index,
    input  logic [7:0]               mux_byte,
    input  logic [7:0]               ks_byte,
    input  logic                     ks_valid,
    output logic                     ks_ready,
    output logic [8*NUM_BYTES-1:0]   out_data,
    output logic [INDEX_WIDTH-1:0]   byte_count,
    output logic                     busy,
    output logic                     done
);

    localparam logic [INDEX_WIDTH-1:0] C_NUM_BYTES = INDEX_WIDTH'(NUM_BYTES);
    localparam logic [INDEX_WIDTH-1:0] C_ONE       = INDEX_WIDTH'(1);
    localparam logic [INDEX_WIDTH-1:0] C_ZERO      = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   r_state;
    logic [INDEX_WIDTH-1:0]   r_len;
    logic [INDEX_WIDTH-1:0]   w_eff_len;
    logic                     w_xfer;
    logic                     w_last;

    // Zero or oversized lengths mean "the whole message".
    assign w_eff_len = ((msg_len == C_ZERO) || (msg_len > C_NUM_BYTES)) ? C_NUM_BYTES : msg_len;
    assign w_xfer    = ks_valid && (r_state == RUN);
    assign w_last    = (mux_index == (r_len - C_ONE));

    assign ks_ready  = (r_state == RUN);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_len      <= C_NUM_BYTES;
            mux_index  <= C_ZERO;
            byte_count <= C_ZERO;
            out_data   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_len      <= w_eff_len;
                        mux_index  <= C_ZERO;
                        byte_count <= C_ZERO;
                        out_data   <= '0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    if (w_xfer) begin
                        for (int k = 0; k < NUM_BYTES; k++) begin
                            if (mux_index == INDEX_WIDTH'(k)) begin
                                out_data[8*k +: 8] <= mux_byte ^ ks_byte;
                            end
                        end
                        byte_count <= byte_count + C_ONE;
                        // Wrap on the final byte so the mux never sees an out-of-range index.
                        if (w_last) begin
                            mux_index <= C_ZERO;
                            r_state   <= DONE;
                        end else begin
                            mux_index <= mux_index + C_ONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_byte_xor_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_xor_sequencer
// Brief    : Directed scoreboard bench for byte_xor_sequencer.
// Revision : 1.0
// ============================================================================
module tb_byte_xor_sequencer;

    logic         clock;
    logic         reset;
    logic         start;
    logic [4:0]   msg_len;
    logic [4:0]   mux_index;
    logic [7:0]   mux_byte;
    logic [7:0]   ks_byte;
    logic         ks_valid;
    logic         ks_ready;
    logic [223:0] out_data;
    logic [4:0]   byte_count;
    logic         busy;
    logic         done;

    logic [7:0]   msg [28];
    logic [223:0] exp_q [$];
    int           checks;
    int           errors;

    byte_xor_sequencer #(
        .NUM_BYTES   (28),
        .INDEX_WIDTH (5)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .msg_len    (msg_len),
        .mux_index  (mux_index),
        .mux_byte   (mux_byte),
        .ks_byte    (ks_byte),
        .ks_valid   (ks_valid),
        .ks_ready   (ks_ready),
        .out_data   (out_data),
        .byte_count (byte_count),
        .busy       (busy),
        .done       (done)
    );

    // Combinational mux model; an out-of-range index returns a poison value.
    assign mux_byte = (mux_index < 5'd28) ? msg[mux_index] : 8'hEE;

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [223:0] obs, input logic [223:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Caller is just past a negedge; returns just past a negedge in IDLE.
    task automatic run_pass(input int len_in, input logic [7:0] ks_base, input logic [7:0] ks_step,
                            input int gap, input int restart_at, input int reset_at);
        int           len_eff;
        int           i;
        int           g;
        int           t;
        logic         restarted;
        logic [223:0] expv;
        logic [223:0] got;

        len_eff = ((len_in == 0) || (len_in > 28)) ? 28 : len_in;
        expv = '0;
        for (int k = 0; k < len_eff; k++) begin
            expv[8*k +: 8] = msg[k] ^ (ks_base + ks_step * 8'(k));
        end
        if (reset_at < 0) exp_q.push_back(expv);

        start    = 1'b1;
        msg_len  = 5'(len_in);
        ks_valid = 1'b0;
        @(negedge clock);
        start   = 1'b0;
        msg_len = 5'd5;
        check("entry_busy",     224'(busy),       224'(1));
        check("entry_ks_ready", 224'(ks_ready),   224'(1));
        check("entry_cleared",  out_data,         224'(0));
        check("entry_count",    224'(byte_count), 224'(0));

        i = 0; g = 0; t = 1; restarted = 1'b0;
        while ((done !== 1'b1) && (t < 200)) begin
            check("mux_index",       224'(mux_index),          224'(i));
            check("mux_index_range", 224'(mux_index < 5'd28),  224'(1));
            check("byte_count",      224'(byte_count),         224'(i));
            check("run_ks_ready",    224'(ks_ready),           224'(1));
            start = 1'b0;
            if ((i == restart_at) && !restarted) begin
                start     = 1'b1;
                msg_len   = 5'd2;
                restarted = 1'b1;
            end
            if ((g == 0) && (i < len_eff)) begin
                ks_valid = 1'b1;
                ks_byte  = ks_base + ks_step * 8'(i);
                if (i == reset_at) begin
                    reset = 1'b1;
                    @(negedge clock);
                    reset    = 1'b0;
                    ks_valid = 1'b0;
                    start    = 1'b0;
                    check("rst_busy",      224'(busy),       224'(0));
                    check("rst_ks_ready",  224'(ks_ready),   224'(0));
                    check("rst_done",      224'(done),       224'(0));
                    check("rst_out_data",  out_data,         224'(0));
                    check("rst_mux_index", 224'(mux_index),  224'(0));
                    check("rst_count",     224'(byte_count), 224'(0));
                    return;
                end
                i++;
                g = gap;
            end else begin
                ks_valid = 1'b0;
                ks_byte  = 8'($urandom);
                if (g > 0) g--;
            end
            @(negedge clock);
            t++;
        end
        start    = 1'b0;
        ks_valid = 1'b0;

        check("done_seen",    224'(done),       224'(1));
        check("done_latency", 224'(t),          224'(len_eff + 1 + gap * (len_eff - 1)));
        got = exp_q.pop_front();
        check("out_data",     out_data,         got);
        check("final_count",  224'(byte_count), 224'(len_eff));
        check("final_index",  224'(mux_index),  224'(0));

        @(negedge clock);
        check("done_one_cycle", 224'(done),     224'(0));
        check("idle_busy",      224'(busy),     224'(0));
        check("idle_ks_ready",  224'(ks_ready), 224'(0));
        check("idle_hold",      out_data,       got);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        clock    = 1'b0;
        reset    = 1'b1;
        start    = 1'b0;
        msg_len  = 5'd0;
        ks_valid = 1'b0;
        ks_byte  = 8'h00;
        for (int k = 0; k < 28; k++) msg[k] = 8'(k);

        repeat (2) @(negedge clock);
        check("reset_busy",     224'(busy),       224'(0));
        check("reset_done",     224'(done),       224'(0));
        check("reset_ks_ready", 224'(ks_ready),   224'(0));
        check("reset_index",    224'(mux_index),  224'(0));
        check("reset_count",    224'(byte_count), 224'(0));
        check("reset_out_data", out_data,         224'(0));
        reset = 1'b0;

        // Keystream offered while idle must be ignored.
        for (int c = 0; c < 5; c++) begin
            ks_valid = c[0] ? 1'b0 : 1'b1;
            ks_byte  = 8'($urandom);
            @(negedge clock);
            check("idle_out_data", out_data,         224'(0));
            check("idle_count",    224'(byte_count), 224'(0));
            check("idle_index",    224'(mux_index),  224'(0));
            check("idle_ready",    224'(ks_ready),   224'(0));
            check("idle_done",     224'(done),       224'(0));
        end
        ks_valid = 1'b0;

        run_pass(28, 8'hA5, 8'h00, 0, -1, -1);

        for (int k = 0; k < 28; k++) msg[k] = 8'($urandom);
        run_pass(3, 8'h01, 8'h01, 2, -1, -1);

        run_pass(0,  8'h5C, 8'h03, 0, -1, -1);
        run_pass(31, 8'h9A, 8'h07, 0, -1, -1);

        run_pass(28, 8'h3C, 8'h01, 0, 10, -1);
        for (int k = 0; k < 28; k++) msg[k] = 8'($urandom);
        run_pass(12, 8'hC3, 8'h05, 1, -1, -1);

        run_pass(28, 8'h77, 8'h02, 0, -1, 14);
        run_pass(28, 8'h11, 8'h01, 0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
